// File: rtl/fpsqrt_pkg.sv
// Shared types and helpers for the single-precision square-root stream unit.
// Latency: n/a (package of types and combinational functions).
// Backpressure: n/a.
package fpsqrt_pkg;

  localparam int FP_SP_W = 34;

  typedef enum logic [1:0] {
    EXN_ZERO = 2'b00,
    EXN_NORM = 2'b01,
    EXN_INF  = 2'b10,
    EXN_NAN  = 2'b11
  } exn_e;

  typedef struct packed {
    exn_e        exn;
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp_sp_t;

  // sqrt of a negative normal or of -inf has no real result
  function automatic logic fp_is_invalid_sqrt(input fp_sp_t x);
    return ((x.exn == EXN_NORM) || (x.exn == EXN_INF)) && x.sign;
  endfunction

  // Correctly rounded (nearest) square root. NaN results are emitted in a
  // single canonical encoding {11,0,0,0}; zeros keep their sign.
  function automatic fp_sp_t fp_sqrt_sp(input fp_sp_t x);
    fp_sp_t      r;
    logic [47:0] rad;
    logic [23:0] q;
    logic [26:0] rem;
    logic [26:0] trial;
    logic [8:0]  esum;
    r     = '0;
    rad   = '0;
    q     = '0;
    rem   = '0;
    trial = '0;
    esum  = '0;
    case (x.exn)
      EXN_ZERO: begin
        r.exn  = EXN_ZERO;
        r.sign = x.sign;
      end
      EXN_INF: r.exn = x.sign ? EXN_NAN : EXN_INF;
      EXN_NAN: r.exn = EXN_NAN;
      default: begin
        if (x.sign) begin
          r.exn = EXN_NAN;
        end else begin
          // odd unbiased exponent: fold one factor of 2 into the mantissa
          if (x.exp[0]) rad = {1'b0, 1'b1, x.frac, 23'd0};
          else          rad = {1'b1, x.frac, 24'd0};
          // two result bits per step; remainder ends as rad - q*q
          for (int i = 23; i >= 0; i--) begin
            rem   = {rem[24:0], rad[2*i +: 2]};
            trial = {1'b0, q, 2'b01};
            if (rem >= trial) begin
              rem = rem - trial;
              q   = {q[22:0], 1'b1};
            end else begin
              q   = {q[22:0], 1'b0};
            end
          end
          // no ties exist for sqrt; rounding up never carries out of 24 bits
          if (rem > {3'd0, q}) q = q + 24'd1;
          esum   = {1'b0, x.exp} + 9'd127;
          r.exn  = EXN_NORM;
          r.exp  = esum[8:1];
          r.frac = q[22:0];
        end
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sqrt_result_fifo.sv
// Result buffer with a registered head: holds {r,tag,inv} in arrival order and reports its fill count.
// Latency: a write into an empty buffer is visible on rd_vld_o/rd_dat_o the next cycle.
// Backpressure: rd_dat_o holds while rd_vld_o && !rd_rdy_i; write+read allowed at any count incl. full.
module sqrt_result_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_vld_i,
  input  logic [WIDTH-1:0]           wr_dat_i,
  input  logic                       rd_rdy_i,
  output logic                       rd_vld_o,
  output logic [WIDTH-1:0]           rd_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push       = wr_vld_i;
  assign pop        = rd_rdy_i && (count_q != '0);
  assign rd_ptr_nxt = ptr_inc(rd_ptr_q);

  // next pointers, fill count and the value the head register must show
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_nxt         : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q)  : wr_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    head_d = head_q;
    // incoming word becomes head when it lands in an empty (or emptying) buffer
    if (push && ((count_q == '0) || (pop && (count_q == CW'(1))))) begin
      head_d = wr_dat_i;
    end else if (pop && (count_q > CW'(1))) begin
      head_d = mem_q[rd_ptr_nxt];
    end
  end

  // storage array: data only, validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  // control state and registered head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign rd_vld_o = (count_q != '0);
  assign rd_dat_o = head_q;
  assign count_o  = count_q;

endmodule

// File: rtl/fpsqrt_sp_stream.sv
// Streaming single-precision sqrt: fixed pipeline with valid/tag/invalid sideband and a result buffer.
// Latency: NUM_STAGES+1 cycles from accept to out_valid when the buffer is empty; 1 op/cycle.
// Backpressure: credit admission (in_ready from registered state only) so the core never stalls.
module fpsqrt_sp_stream
  import fpsqrt_pkg::*;
#(
  parameter int NUM_STAGES = 8,
  parameter int TAG_W      = 4,
  parameter int OUT_DEPTH  = NUM_STAGES + 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FP_SP_W-1:0] in_x,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FP_SP_W-1:0] out_r,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_inv,
  output logic               busy
);

  localparam int IFW   = $clog2(NUM_STAGES + 1);
  localparam int BCW   = $clog2(OUT_DEPTH + 1);
  localparam int SUM_W = ((IFW > BCW) ? IFW : BCW) + 1;
  localparam int ENT_W = FP_SP_W + TAG_W + 1;

  if (!(((NUM_STAGES >= 1) && (NUM_STAGES <= 8)) || (NUM_STAGES == 16))) begin : g_bad_stages
    $error("fpsqrt_sp_stream: NUM_STAGES=%0d unsupported (1..8 or 16)", NUM_STAGES);
  end
  if (OUT_DEPTH < 1) begin : g_bad_depth
    $error("fpsqrt_sp_stream: OUT_DEPTH=%0d must be >= 1", OUT_DEPTH);
  end

  fp_sp_t           dat_q [NUM_STAGES];
  logic             vld_q [NUM_STAGES];
  logic [TAG_W-1:0] tag_q [NUM_STAGES];
  logic             inv_q [NUM_STAGES];

  logic [IFW-1:0]   inflight_q, inflight_d;
  logic [BCW-1:0]   buf_count;
  logic [SUM_W-1:0] used, credits;
  logic             accept, retire;
  logic [ENT_W-1:0] wr_dat, rd_dat;

  // credits = OUT_DEPTH - buffered - inflight; every accepted op owns a buffer slot
  assign used     = SUM_W'(buf_count) + SUM_W'(inflight_q);
  assign credits  = SUM_W'(OUT_DEPTH) - used;
  assign in_ready = (credits != '0);
  assign accept   = in_valid && in_ready;
  assign retire   = vld_q[NUM_STAGES-1];

  // core datapath: always enabled, unreset; stale contents are masked by vld_q
  always_ff @(posedge clk) begin
    dat_q[0] <= fp_sqrt_sp(fp_sp_t'(in_x));
    for (int i = 1; i < NUM_STAGES; i++) dat_q[i] <= dat_q[i-1];
  end

  // valid/tag/invalid sideband travels in lockstep with the core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
        inv_q[i] <= 1'b0;
      end
    end else begin
      vld_q[0] <= accept;
      tag_q[0] <= in_tag;
      inv_q[0] <= fp_is_invalid_sqrt(fp_sp_t'(in_x));
      for (int i = 1; i < NUM_STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
        inv_q[i] <= inv_q[i-1];
      end
    end
  end

  // inflight count: up on accept, down when an op leaves the last stage
  always_comb begin
    unique case ({accept, retire})
      2'b10:   inflight_d = inflight_q + IFW'(1);
      2'b01:   inflight_d = inflight_q - IFW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // inflight register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= '0;
    else        inflight_q <= inflight_d;
  end

  assign wr_dat = {dat_q[NUM_STAGES-1], tag_q[NUM_STAGES-1], inv_q[NUM_STAGES-1]};

  sqrt_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (OUT_DEPTH)
  ) u_res_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_vld_i (retire),
    .wr_dat_i (wr_dat),
    .rd_rdy_i (out_ready),
    .rd_vld_o (out_valid),
    .rd_dat_o (rd_dat),
    .count_o  (buf_count)
  );

  assign {out_r, out_tag, out_inv} = rd_dat;
  assign busy = (inflight_q != '0) || (buf_count != '0);

endmodule

// File: tb/tb_fpsqrt_sp_stream.sv
// Self-checking bench for fpsqrt_sp_stream: directed table, streaming, backpressure, random, reset.
// Reference: exact-integer sqrt model plus a timed scoreboard of expected results.
// All checks and stimulus happen on the falling edge.
module tb_fpsqrt_sp_stream;

  localparam int NS    = 8;
  localparam int DEPTH = NS + 2;
  localparam logic [33:0] CNAN = 34'h3_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [33:0] in_x;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [33:0] out_r;
  logic [3:0]  out_tag;
  logic        out_inv, busy;

  always #5 clk = ~clk;

  fpsqrt_sp_stream #(.NUM_STAGES(NS), .TAG_W(4), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag),
    .out_inv(out_inv), .busy(busy)
  );

  typedef struct {
    logic [33:0] r;
    logic [3:0]  tag;
    logic        inv;
    int          due;
  } exp_t;

  typedef struct {
    string       name;
    logic [33:0] x;
    logic [3:0]  tag;
    logic [33:0] exp_r;
    logic        exp_inv;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // value-level model: sqrt(m * 2^(e-23)) with an even exponent, rounded to nearest
  function automatic logic [33:0] ref_sqrt(input logic [33:0] x);
    logic [1:0] exn;
    logic       s;
    int         ue, re;
    longint     m, rad, q;
    exn = x[33:32];
    s   = x[31];
    if (exn == 2'b00) return {2'b00, s, 31'd0};
    if (exn == 2'b11 || s) return CNAN;
    if (exn == 2'b10) return 34'h2_0000_0000;
    m  = longint'({1'b1, x[22:0]});
    ue = int'(x[30:23]) - 127;
    if (ue % 2 != 0) begin
      m  = m * 2;
      ue = ue - 1;
    end
    rad = m * 64'd8388608;
    q   = longint'($rtoi($sqrt(real'(rad))));
    while (q * q > rad) q--;
    while ((q + 1) * (q + 1) <= rad) q++;
    if (rad - q * q > q) q++;
    re = ue / 2 + 127;
    return {2'b01, 1'b0, 8'(re), q[22:0]};
  endfunction

  function automatic logic ref_inv(input logic [33:0] x);
    return ((x[33:32] == 2'b01) || (x[33:32] == 2'b10)) && x[31];
  endfunction

  function automatic logic [33:0] rand_x();
    logic [31:0] w;
    int          sel;
    w   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 7)  return {2'b01, w};
    if (sel == 7) return {2'b00, w};
    if (sel == 8) return {2'b10, w};
    return {2'b11, w};
  endfunction

  task automatic add_vec(input string nm, input logic [33:0] x, input logic [3:0] tag,
                         input logic [33:0] r, input logic inv);
    vec_t v;
    v.name = nm; v.x = x; v.tag = tag; v.exp_r = r; v.exp_inv = inv;
    vecs.push_back(v);
  endtask

  // one clock: check DUT against the timed scoreboard, then drive the next inputs
  task automatic cycle(input logic v, input logic [33:0] x, input logic [3:0] tag, input logic rdy);
    logic exp_vld, exp_rdy;
    exp_t e;
    @(negedge clk);
    cyc++;
    exp_vld = (sb.size() > 0) && (sb[0].due <= cyc);
    exp_rdy = (sb.size() < DEPTH);
    check("out_valid", 64'(out_valid), 64'(exp_vld));
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(sb.size() != 0));
    if (exp_vld && out_valid)
      check("result", 64'({out_r, out_tag, out_inv}), 64'({sb[0].r, sb[0].tag, sb[0].inv}));
    in_valid = v; in_x = x; in_tag = tag; out_ready = rdy;
    if (exp_vld && rdy) void'(sb.pop_front());
    if (v && exp_rdy) begin
      e.r = ref_sqrt(x); e.tag = tag; e.inv = ref_inv(x); e.due = cyc + NS + 1;
      sb.push_back(e);
    end
  endtask

  // single op into an idle unit; latency and fields checked against table constants
  task automatic one_op(input vec_t v);
    int k;
    cycle(1'b1, v.x, v.tag, 1'b1);
    k = 0;
    do begin
      cycle(1'b0, 34'd0, 4'd0, 1'b1);
      k++;
    end while (!out_valid && k < 4 * NS + 8);
    check({v.name, "_latency"}, 64'(k), 64'(NS + 1));
    check({v.name, "_r"}, 64'(out_r), 64'(v.exp_r));
    check({v.name, "_tag"}, 64'(out_tag), 64'(v.tag));
    check({v.name, "_inv"}, 64'(out_inv), 64'(v.exp_inv));
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_out_valid"}, 64'(out_valid), 64'd0);
    check({nm, "_busy"}, 64'(busy), 64'd0);
    check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    check({nm, "_out_r"}, 64'(out_r), 64'd0);
    check({nm, "_out_tag"}, 64'(out_tag), 64'd0);
    check({nm, "_out_inv"}, 64'(out_inv), 64'd0);
  endtask

  initial begin
    int dut_acc, dut_pop, first_pop, last_pop, guard, acc_goal;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_tag = '0; out_ready = 1'b0;

    add_vec("sqrt_4",    34'h1_4080_0000, 4'd3,  34'h1_4000_0000, 1'b0);
    add_vec("sqrt_neg4", 34'h1_C080_0000, 4'd5,  CNAN,           1'b1);
    add_vec("sqrt_neg0", 34'h0_8000_0000, 4'd6,  34'h0_8000_0000, 1'b0);
    add_vec("sqrt_pos0", 34'h0_0000_0000, 4'd7,  34'h0_0000_0000, 1'b0);
    add_vec("sqrt_pinf", 34'h2_0000_0000, 4'd8,  34'h2_0000_0000, 1'b0);
    add_vec("sqrt_ninf", 34'h2_8000_0000, 4'd9,  CNAN,           1'b1);
    add_vec("sqrt_nan",  34'h3_7FC0_0000, 4'd10, CNAN,           1'b0);
    add_vec("sqrt_2",    34'h1_4000_0000, 4'd11, 34'h1_3FB5_04F3, 1'b0);
    add_vec("sqrt_0p25", 34'h1_3E80_0000, 4'd12, 34'h1_3F00_0000, 1'b0);
    add_vec("sqrt_9",    34'h1_4110_0000, 4'd15, 34'h1_4040_0000, 1'b0);

    repeat (2) @(negedge clk);
    check_reset_outs("por");
    rst_n = 1'b1;

    // directed single operations
    foreach (vecs[i]) one_op(vecs[i]);

    // back-to-back streaming, consumer always ready
    dut_acc = 0; dut_pop = 0; first_pop = -1; last_pop = -1;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, rand_x(), 4'(i % 16), 1'b1);
      dut_acc += int'(in_ready);
      if (out_valid) begin
        dut_pop++; last_pop = cyc;
        if (first_pop < 0) first_pop = cyc;
      end
    end
    guard = 0;
    while (sb.size() > 0 && guard < 4 * NS + 8) begin
      cycle(1'b0, 34'd0, 4'd0, 1'b1);
      guard++;
      if (out_valid) begin
        dut_pop++; last_pop = cyc;
        if (first_pop < 0) first_pop = cyc;
      end
    end
    check("stream_accepts", 64'(dut_acc), 64'd100);
    check("stream_results", 64'(dut_pop), 64'd100);
    check("stream_contiguous", 64'(last_pop - first_pop + 1), 64'd100);

    // backpressure: consumer stalled while producer keeps offering
    dut_acc = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, rand_x(), 4'(i % 16), 1'b0);
      dut_acc += int'(in_ready);
    end
    check("bp_accepts", 64'(dut_acc), 64'(DEPTH));
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    dut_pop = 0; guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      cycle(1'b0, 34'd0, 4'd0, 1'b1);
      guard++;
      if (out_valid) dut_pop++;
    end
    check("bp_released", 64'(dut_pop), 64'(DEPTH));

    // random traffic on both sides
    acc_goal = 10000; dut_acc = 0; guard = 0;
    while (dut_acc < acc_goal && guard < 60000) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      cycle(v, rand_x(), 4'($urandom), 1'($urandom_range(0, 1)));
      if (v && in_ready) dut_acc++;
      guard++;
    end
    check("rand_accepts", 64'(dut_acc), 64'(acc_goal));
    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      cycle(1'b0, 34'd0, 4'd0, 1'b1);
      guard++;
    end

    // reset with 3 results buffered and 5 still in the pipe
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_x(), 4'(i), 1'b0);
    for (int i = 0; i < NS + 1; i++) cycle(1'b0, 34'd0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_x(), 4'(i + 3), 1'b0);
    cycle(1'b0, 34'd0, 4'd0, 1'b0);
    check("pre_reset_busy", 64'(busy), 64'd1);
    check("pre_reset_out_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("midrst");
    sb.delete();
    repeat (2) @(negedge clk);
    check_reset_outs("midrst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 3 * NS; i++) cycle(1'b0, 34'd0, 4'd0, 1'b1);
    one_op(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
